// File: rtl/ama_appr4_24bit_6appr.sv
// ama_appr4_24bit_6appr
//   Approximate ripple-carry adder for error-tolerant datapaths. The low APPR_BITS
//   positions are built from Approximate Mirror Adder type 4 (AMA4) cells. The
//   remaining upper positions are exact full adders. Sum and carry-out are registered,
//   so the result appears one cycle after a qualified input.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   A          in   WIDTH  operand A, unsigned
//   B          in   WIDTH  operand B, unsigned
//   Cin        in   1      carry-in to bit 0
//   in_valid   in   1      A/B/Cin qualified this cycle
//   S          out  WIDTH  registered approximate sum (wraps modulo 2^WIDTH)
//   Cout       out  1      registered carry-out of bit WIDTH-1
//   out_valid  out  1      S/Cout hold the result of a qualified input
module ama_appr4_24bit_6appr #(
    parameter int unsigned WIDTH     = 24,
    parameter int unsigned APPR_BITS = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             out_valid
);

    logic [WIDTH-1:0] s_d, s_q;
    logic             cout_d, cout_q;
    logic             valid_q;

    // Ripple chain. An AMA4 cell passes A[i] straight through as its carry, so the carry
    // into the first exact bit is simply A[APPR_BITS-1].
    always_comb begin
        logic c;
        c   = Cin;
        s_d = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (i < int'(APPR_BITS)) begin
                s_d[i] = ~A[i] & (B[i] | c);
                c      = A[i];
            end else begin
                s_d[i] = A[i] ^ B[i] ^ c;
                c      = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
            end
        end
        cout_d = c;
    end

    // Result registers load only on a qualified input; the valid flag follows in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q     <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                s_q    <= s_d;
                cout_q <= cout_d;
            end
        end
    end

    assign S         = s_q;
    assign Cout      = cout_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_ama_appr4_24bit_6appr.sv
module tb_ama_appr4_24bit_6appr;

    localparam int W  = 24;
    localparam int AB = 6;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  a, b;
    logic          cin;
    logic          in_valid;
    logic [W-1:0]  s;
    logic          cout;
    logic          out_valid;

    int n_cmp;
    int n_err;

    ama_appr4_24bit_6appr #(
        .WIDTH    (W),
        .APPR_BITS(AB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (a),
        .B        (b),
        .Cin      (cin),
        .in_valid (in_valid),
        .S        (s),
        .Cout     (cout),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_s;
        logic         exp_cout;
    } vec_t;

    // Reference: approximate low field from the cell equations applied word-wide
    // (carry into bit i of the low field is Cin for i=0, else A[i-1]); the upper field
    // is an ordinary integer sum seeded with the carry leaving the low field.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic mcin, output logic [W-1:0] ms,
                                  output logic mco);
        logic [W-1:0] mask;
        logic [W-1:0] cvec;
        logic [W-1:0] lo;
        logic [W:0]   up;
        logic         c_up;
        mask = (W'(1) << AB) - W'(1);
        cvec = (ma << 1) | W'(mcin);
        lo   = ~ma & (mb | cvec) & mask;
        c_up = (AB == 0) ? mcin : ma[AB-1];
        up   = ({1'b0, ma} >> AB) + ({1'b0, mb} >> AB) + (W+1)'(c_up);
        ms   = lo | (up[W-1:0] << AB);
        mco  = up[W-AB];
    endfunction

    task automatic check(input string name, input logic [W-1:0] exp_s, input logic exp_co,
                         input logic exp_v);
        n_cmp++;
        if (s !== exp_s || cout !== exp_co || out_valid !== exp_v) begin
            n_err++;
            $display("FAIL %s: got S=%06h Cout=%b valid=%b, want S=%06h Cout=%b valid=%b",
                     name, s, cout, out_valid, exp_s, exp_co, exp_v);
        end
    endtask

    task automatic drive(input logic [W-1:0] da, input logic [W-1:0] db, input logic dc,
                         input logic dv);
        a        = da;
        b        = db;
        cin      = dc;
        in_valid = dv;
        @(posedge clk);
        #1;
    endtask

    vec_t         tbl[6];
    logic [W-1:0] ms, hold_s;
    logic         mco, hold_co;
    logic         v;

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        in_valid = 1'b0;

        tbl[0] = '{24'h000000, 24'h000000, 1'b0, 24'h000000, 1'b0};
        tbl[1] = '{24'h000001, 24'h000000, 1'b0, 24'h000002, 1'b0};
        tbl[2] = '{24'h000020, 24'h000000, 1'b0, 24'h000040, 1'b0};
        tbl[3] = '{24'hFFFFFF, 24'h000001, 1'b0, 24'h000000, 1'b1};
        tbl[4] = '{24'h000040, 24'h000040, 1'b0, 24'h000080, 1'b0};
        tbl[5] = '{24'h000000, 24'h00003F, 1'b0, 24'h00003F, 1'b0};

        #12;
        check("reset_state", 24'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].a, tbl[i].b, tbl[i].cin, 1'b1);
            check($sformatf("table_%0d", i), tbl[i].exp_s, tbl[i].exp_cout, 1'b1);
        end

        // in_valid=0: outputs hold, valid drops
        drive(24'h123456, 24'h654321, 1'b1, 1'b1);
        model(24'h123456, 24'h654321, 1'b1, ms, mco);
        check("load_before_hold", ms, mco, 1'b1);
        drive(24'hABCDEF, 24'h111111, 1'b0, 1'b0);
        check("hold_1", ms, mco, 1'b0);
        drive(24'h000FFF, 24'hFFF000, 1'b1, 1'b0);
        check("hold_2", ms, mco, 1'b0);

        // Async reset mid-stream, no clock edge in between
        drive(24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b1);
        model(24'hFFFFFF, 24'hFFFFFF, 1'b1, ms, mco);
        check("pre_reset", ms, mco, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset", 24'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(24'h00003F, 24'h000001, 1'b1, 1'b1);
        model(24'h00003F, 24'h000001, 1'b1, ms, mco);
        check("first_after_reset", ms, mco, 1'b1);

        // Random stream, one vector per cycle, with occasional idle cycles
        hold_s  = s;
        hold_co = cout;
        for (int i = 0; i < 10000; i++) begin
            logic [W-1:0] ra, rb;
            logic         rc;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            if ($urandom_range(0, 15) == 0) ra = '1;
            if ($urandom_range(0, 15) == 0) rb = '0;
            v = ($urandom_range(0, 7) != 0);
            drive(ra, rb, rc, v);
            if (v) begin
                model(ra, rb, rc, hold_s, hold_co);
            end
            check("random", hold_s, hold_co, v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
